// File: rtl/instruction_decoder_if.sv
// rtl/instruction_decoder_if.sv - instruction decoder bus between program memory, sequencer and datapath
//
// Purpose: bundles the instruction-side inputs and the decoded control outputs
// of instruction_decoder so they can be passed as one port.
// Ports (signals):
//   ir[7:0], pc_big[9:0], alu_zero          instruction/datapath side -> decoder
//   jmp, jmp_nz, dont_jmp, jmp_addr[3:0],
//   jmp_addr_big[9:0], reg_en[7:0],
//   src_sel[3:0], imm[3:0], alu_func[3:0],
//   armed                                   decoder -> sequencer/datapath
// Modports: master drives the instruction side, slave is the decoder.
interface instruction_decoder_if;
   logic [7:0] ir;
   logic [9:0] pc_big;
   logic       alu_zero;
   logic       jmp;
   logic       jmp_nz;
   logic       dont_jmp;
   logic [3:0] jmp_addr;
   logic [9:0] jmp_addr_big;
   logic [7:0] reg_en;
   logic [3:0] src_sel;
   logic [3:0] imm;
   logic [3:0] alu_func;
   logic       armed;

   modport master (
      output ir, pc_big, alu_zero,
      input  jmp, jmp_nz, dont_jmp, jmp_addr, jmp_addr_big,
             reg_en, src_sel, imm, alu_func, armed
   );

   modport slave (
      input  ir, pc_big, alu_zero,
      output jmp, jmp_nz, dont_jmp, jmp_addr, jmp_addr_big,
             reg_en, src_sel, imm, alu_func, armed
   );
endinterface

// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - 8-bit ISA decoder with zero flag and page-prefix FSM
//
// Purpose: decodes the current instruction combinationally into jump,
// register-file and ALU controls; keeps the zero flag and a page-prefix FSM
// that forms the 10-bit jump target.
// Ports:
//   clk         in   system clock, rising edge
//   sync_reset  in   synchronous active-high reset
//   bus         slave modport of instruction_decoder_if (see that file)
module instruction_decoder (
   input logic                   clk,
   input logic                   sync_reset,
   instruction_decoder_if.slave  bus
);

   typedef enum logic {NORMAL = 1'b0, ARMED = 1'b1} page_state_t;

   page_state_t state, state_nxt;
   logic [5:0]  pend_page, pend_page_nxt;
   logic        zflag, zflag_nxt;

   logic       dec_jmp, dec_jmp_nz;
   logic [7:0] dec_reg_en;
   logic [3:0] dec_src_sel;

   // Instruction decode; reset only masks the action outputs.
   always_comb begin
      dec_jmp     = 1'b0;
      dec_jmp_nz  = 1'b0;
      dec_reg_en  = 8'h00;
      dec_src_sel = 4'd0;
      if (!bus.ir[7]) begin
         dec_reg_en[bus.ir[6:4]] = 1'b1;
         dec_src_sel             = 4'd8;
      end else if (!bus.ir[6]) begin
         // MOV with dst == src is the NOP encoding
         if (bus.ir[5:3] != bus.ir[2:0])
            dec_reg_en[bus.ir[5:3]] = 1'b1;
         dec_src_sel = {1'b0, bus.ir[2:0]};
      end else begin
         case (bus.ir[5:4])
            2'b00: begin
               dec_reg_en[0] = 1'b1;
               dec_src_sel   = 4'd9;
            end
            2'b10:   dec_jmp    = 1'b1;
            2'b11:   dec_jmp_nz = 1'b1;
            default: ;
         endcase
      end
   end

   // Next-state for the page FSM, pending page and zero flag.
   always_comb begin
      state_nxt     = state;
      pend_page_nxt = pend_page;
      zflag_nxt     = zflag;
      if (sync_reset) begin
         state_nxt     = NORMAL;
         pend_page_nxt = 6'd0;
         zflag_nxt     = 1'b0;
      end else if (bus.ir[7:4] == 4'b1100) begin
         zflag_nxt = bus.alu_zero;
      end else if (bus.ir[7:4] == 4'b1101) begin
         state_nxt = ARMED;
         if (bus.ir[3])
            pend_page_nxt[5:3] = bus.ir[2:0];
         else
            pend_page_nxt[2:0] = bus.ir[2:0];
      end else if (bus.ir[7:5] == 3'b111) begin
         // any JMP/JNZ consumes the prefix, taken or not
         state_nxt = NORMAL;
      end
   end

   always_ff @(posedge clk) begin
      state     <= state_nxt;
      pend_page <= pend_page_nxt;
      zflag     <= zflag_nxt;
   end

   assign bus.jmp          = dec_jmp & ~sync_reset;
   assign bus.jmp_nz       = dec_jmp_nz & ~sync_reset;
   assign bus.reg_en       = sync_reset ? 8'h00 : dec_reg_en;
   assign bus.src_sel      = dec_src_sel;
   assign bus.dont_jmp     = zflag;
   assign bus.jmp_addr     = bus.ir[3:0];
   assign bus.imm          = bus.ir[3:0];
   assign bus.alu_func     = bus.ir[3:0];
   assign bus.armed        = (state == ARMED);
   assign bus.jmp_addr_big = (state == ARMED) ? {pend_page, bus.ir[3:0]}
                                              : {bus.pc_big[9:4], bus.ir[3:0]};

endmodule

// File: tb/tb_instruction_decoder.sv
// tb/tb_instruction_decoder.sv - scoreboard bench for instruction_decoder
module tb_instruction_decoder;

   logic clk = 1'b0;
   logic sync_reset;
   always #5 clk = ~clk;

   instruction_decoder_if bus();

   instruction_decoder dut (
      .clk        (clk),
      .sync_reset (sync_reset),
      .bus        (bus)
   );

   typedef struct {
      logic       rst;
      logic       jmp;
      logic       jmp_nz;
      logic       dont_jmp;
      logic [3:0] jmp_addr;
      logic [9:0] jmp_addr_big;
      logic [7:0] reg_en;
      logic [3:0] src_sel;
      logic [3:0] imm;
      logic       armed;
   } exp_t;

   exp_t sb[$];

   int n_cmp = 0;
   int n_bad = 0;

   // reference state
   logic       m_z     = 1'b0;
   logic       m_armed = 1'b0;
   logic [5:0] m_page  = 6'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one instruction cycle and push the model's expectation.
   task automatic drive(input logic [7:0] i, input logic [9:0] p, input logic az, input logic r);
      exp_t e;
      logic [2:0] dst, src;
      @(posedge clk);
      #1;
      bus.ir       = i;
      bus.pc_big   = p;
      bus.alu_zero = az;
      sync_reset   = r;
      dst = i[5:3];
      src = i[2:0];
      e.rst          = r;
      e.jmp          = 1'b0;
      e.jmp_nz       = 1'b0;
      e.reg_en       = 8'h00;
      e.src_sel      = 4'd0;
      e.imm          = i[3:0];
      e.jmp_addr     = i[3:0];
      e.dont_jmp     = m_z;
      e.armed        = m_armed;
      e.jmp_addr_big = m_armed ? {m_page, i[3:0]} : {p[9:4], i[3:0]};
      if (i[7] == 1'b0) begin
         e.reg_en  = 8'(1) << i[6:4];
         e.src_sel = 4'd8;
      end else if (i[7:6] == 2'b10) begin
         e.reg_en  = (dst == src) ? 8'h00 : (8'(1) << dst);
         e.src_sel = {1'b0, src};
      end else if (i[7:4] == 4'hC) begin
         e.reg_en  = 8'h01;
         e.src_sel = 4'd9;
      end
      e.jmp    = (i[7:4] == 4'hE);
      e.jmp_nz = (i[7:4] == 4'hF);
      if (r) begin
         e.jmp    = 1'b0;
         e.jmp_nz = 1'b0;
         e.reg_en = 8'h00;
         m_z      = 1'b0;
         m_armed  = 1'b0;
         m_page   = 6'd0;
      end else begin
         if (i[7:4] == 4'hC) m_z = az;
         if (i[7:4] == 4'hD) begin
            m_armed = 1'b1;
            if (i[3]) m_page = {i[2:0], m_page[2:0]};
            else      m_page = {m_page[5:3], i[2:0]};
         end
         if (i[7:4] == 4'hE || i[7:4] == 4'hF) m_armed = 1'b0;
      end
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check("jmp",          32'(bus.jmp),          32'(e.jmp));
         check("jmp_nz",       32'(bus.jmp_nz),       32'(e.jmp_nz));
         check("dont_jmp",     32'(bus.dont_jmp),     32'(e.dont_jmp));
         check("jmp_addr",     32'(bus.jmp_addr),     32'(e.jmp_addr));
         check("jmp_addr_big", 32'(bus.jmp_addr_big), 32'(e.jmp_addr_big));
         check("reg_en",       32'(bus.reg_en),       32'(e.reg_en));
         check("imm",          32'(bus.imm),          32'(e.imm));
         check("alu_func",     32'(bus.alu_func),     32'(e.imm));
         check("armed",        32'(bus.armed),        32'(e.armed));
         if (!e.rst)
            check("src_sel",   32'(bus.src_sel),      32'(e.src_sel));
      end
   end

   // Directed spot check of the value present in the current cycle.
   task automatic spot(input string tag, input logic [31:0] got_sel, input logic [31:0] exp);
      check(tag, got_sel, exp);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      sync_reset   = 1'b1;
      bus.ir       = 8'hE5;
      bus.pc_big   = 10'd0;
      bus.alu_zero = 1'b0;

      // reset with a JMP on the bus
      drive(8'hE5, 10'h000, 1'b0, 1'b1); settle();
      spot("rst_jmp", 32'(bus.jmp), 32'd0);
      spot("rst_reg_en", 32'(bus.reg_en), 32'd0);
      drive(8'hE5, 10'h000, 1'b0, 1'b1); settle();

      // decode sweep
      drive(8'h3A, 10'h000, 1'b0, 1'b0); settle();
      spot("post_rst_dont_jmp", 32'(bus.dont_jmp), 32'd0);
      spot("post_rst_armed", 32'(bus.armed), 32'd0);
      spot("load_reg_en", 32'(bus.reg_en), 32'h08);
      spot("load_src_sel", 32'(bus.src_sel), 32'd8);
      spot("load_imm", 32'(bus.imm), 32'hA);
      drive(8'h9A, 10'h000, 1'b0, 1'b0); settle();
      spot("mov_reg_en", 32'(bus.reg_en), 32'h08);
      spot("mov_src_sel", 32'(bus.src_sel), 32'd2);
      drive(8'h9B, 10'h000, 1'b0, 1'b0); settle();
      spot("nop_reg_en", 32'(bus.reg_en), 32'h00);

      // zero flag
      drive(8'hC0, 10'h000, 1'b1, 1'b0);
      drive(8'hF7, 10'h000, 1'b0, 1'b0); settle();
      spot("jnz_req", 32'(bus.jmp_nz), 32'd1);
      spot("z_set", 32'(bus.dont_jmp), 32'd1);
      drive(8'hC0, 10'h000, 1'b0, 1'b0);
      drive(8'hF7, 10'h000, 1'b1, 1'b0); settle();
      spot("z_clr", 32'(bus.dont_jmp), 32'd0);
      drive(8'hC0, 10'h000, 1'b1, 1'b0);
      drive(8'h3A, 10'h000, 1'b0, 1'b0);
      drive(8'hF7, 10'h000, 1'b0, 1'b0); settle();
      spot("z_hold_load", 32'(bus.dont_jmp), 32'd1);

      // normal page jump
      drive(8'hE9, 10'h2A3, 1'b0, 1'b0); settle();
      spot("norm_jmp", 32'(bus.jmp), 32'd1);
      spot("norm_addr", 32'(bus.jmp_addr_big), 32'h2A9);
      spot("norm_armed", 32'(bus.armed), 32'd0);

      // two-half prefix
      drive(8'hD5, 10'h2A3, 1'b0, 1'b0);
      drive(8'hDA, 10'h2A3, 1'b0, 1'b0); settle();
      spot("pfx_armed", 32'(bus.armed), 32'd1);
      drive(8'hE4, 10'h2A3, 1'b0, 1'b0); settle();
      spot("pfx_addr", 32'(bus.jmp_addr_big), 32'h154);
      drive(8'h00, 10'h2A3, 1'b0, 1'b0); settle();
      spot("pfx_disarm", 32'(bus.armed), 32'd0);

      // single-half prefix, persists across ALU, JNZ not taken
      drive(8'hD3, 10'h0F0, 1'b0, 1'b0);
      drive(8'hC1, 10'h0F1, 1'b1, 1'b0); settle();
      spot("alu_keeps_armed", 32'(bus.armed), 32'd1);
      drive(8'hF6, 10'h0F2, 1'b0, 1'b0); settle();
      spot("jnz_pfx_addr", 32'(bus.jmp_addr_big), 32'h136);
      spot("jnz_not_taken", 32'(bus.dont_jmp), 32'd1);
      drive(8'h00, 10'h0F3, 1'b0, 1'b0); settle();
      spot("jnz_disarm", 32'(bus.armed), 32'd0);

      // reset discards pending page
      drive(8'hD1, 10'h3C0, 1'b0, 1'b0);
      drive(8'h00, 10'h3C0, 1'b0, 1'b1);
      drive(8'hE2, 10'h3C0, 1'b0, 1'b0); settle();
      spot("rst_disarm", 32'(bus.armed), 32'd0);
      spot("rst_pc_page", 32'(bus.jmp_addr_big), 32'h3C2);

      // random traffic, scoreboard only
      for (int k = 0; k < 300; k++) begin
         logic [7:0] ri;
         ri = 8'($urandom_range(0, 255));
         if (k % 3 == 0) ri[7:5] = 3'b110;
         drive(ri, 10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 40) == 0));
      end

      settle();
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instruction_decoder.md
# instruction_decoder

Decodes the 8-bit instruction word from program memory into the jump controls consumed by `program_sequencer` and the register-file and ALU controls for the datapath. Every decoded output is combinational from the current instruction and decoder state. The decoder holds two pieces of state:
- the zero flag, which drives `dont_jmp`;
- a page-prefix FSM, which forms the 10-bit jump target `jmp_addr_big`.

It sits between the program memory data output and the sequencer/datapath.

## Interface
Parameters: none (widths fixed by the 8-bit ISA and the 10-bit program address).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `sync_reset`  in  1  reset, synchronous, active-high.
- `ir`  in  8  current instruction (program memory output, aligned with `pc_big`).
- `pc_big`  in  10  address of the current instruction, from the sequencer.
- `alu_zero`  in  1  ALU result-is-zero, combinational from the datapath.
- `jmp`  out  1  unconditional jump request.
- `jmp_nz`  out  1  conditional jump request (jump if not zero).
- `dont_jmp`  out  1  registered zero flag.
- `jmp_addr`  out  4  `ir[3:0]`, the in-page target.
- `jmp_addr_big`  out  10  full jump target.
- `reg_en`  out  8  one-hot register write enable, r0..r7.
- `src_sel`  out  4  source select: 0–7 = r0..r7, 8 = immediate, 9 = ALU result.
- `imm`  out  4  `ir[3:0]`.
- `alu_func`  out  4  ALU function (`ir[3:0]`).
- `armed`  out  1  page-prefix FSM is in ARMED.

## Operation
Instruction encoding:
- `0ddd_vvvv` LOAD: `reg_en[ddd]`=1, `src_sel`=8.
- `10dd_dsss` MOV: dst=`ir[5:3]`, src=`ir[2:0]`, so `reg_en[dst]`=1 and `src_sel`=src.
  - If dst==src, the instruction is a NOP: `reg_en`=0.
- `1100_ffff` ALU: `reg_en[0]`=1, `src_sel`=9, `alu_func`=ffff; the zero flag Z loads `alu_zero` at the clock edge.
- `1101_hppp` PAGE prefix: no register writes.
  - h=0 loads `pend_page[2:0]`=ppp.
  - h=1 loads `pend_page[5:3]`=ppp.
  - FSM goes to ARMED.
- `1110_aaaa` JMP: `jmp`=1.
- `1111_aaaa` JNZ: `jmp_nz`=1.
- For every non-applicable output, the value is 0. `alu_func` and `imm` are always `ir[3:0]`.

Page FSM, states NORMAL and ARMED:
- In NORMAL, `jmp_addr_big` = {`pc_big[9:4]`, `ir[3:0]`}, i.e. the current page.
- In ARMED, `jmp_addr_big` = {`pend_page`, `ir[3:0]`}.
- NORMAL→ARMED on any PAGE prefix.
- ARMED→NORMAL at the edge ending any JMP or JNZ, whether taken or not.
- ARMED persists across LOAD, MOV and ALU instructions.
- A PAGE prefix while ARMED updates only the addressed 3 bits; the other 3 bits keep their value.
- `pend_page` holds its value on return to NORMAL. A single-half prefix therefore reuses the other half from the previous prefix.

Zero flag:
- Z changes only on ALU instructions.
- `dont_jmp`=Z for all instructions. The sequencer uses it only with `jmp_nz`.

## Timing
- All outputs are combinational from `ir`, `pc_big` and registered state, with zero-cycle decode latency.
- State (Z, FSM, `pend_page`) updates at the rising edge that ends the instruction.
- An ALU instruction immediately followed by JNZ: the JNZ sees the new Z. No bypass is needed.
- While `sync_reset`=1:
  - `jmp`=0, `jmp_nz`=0, `reg_en`=0.
  - At the edge: Z←0, FSM←NORMAL, `pend_page`←0.
  - `dont_jmp` and `armed` therefore read 0 the cycle after reset.
  - `src_sel`, `imm` and `alu_func` still follow `ir` (don't care).
- Reset asserted while ARMED discards the pending page.
- Reset takes priority over every instruction in the same cycle.

## Test plan
- Reset: drive `ir`=8'hE5 with `sync_reset`=1 for 2 cycles → `jmp`=0, `reg_en`=0; after release `dont_jmp`=0 and `armed`=0.
- Decode sweep:
  - `ir`=8'h3A → `reg_en`=8'h08, `src_sel`=8, `imm`=4'hA.
  - `ir`=8'h9A (MOV r3←r2) → `reg_en`=8'h08, `src_sel`=2.
  - `ir`=8'h9B (MOV r3←r3) → `reg_en`=0.
- Zero flag:
  - ALU with `alu_zero`=1, then `ir`=8'hF7 → `jmp_nz`=1, `dont_jmp`=1.
  - Repeat with `alu_zero`=0 → `dont_jmp`=0.
  - LOAD between the ALU and the JNZ leaves Z unchanged.
- Normal page: `pc_big`=10'h2A3, `ir`=8'hE9 → `jmp`=1, `jmp_addr_big`=10'h2A9, `armed`=0.
- Prefix sequence:
  - Issue 8'hD5 then 8'hDA → `armed`=1.
  - Next `ir`=8'hE4 → `jmp_addr_big`={6'b010101, 4'h4}=10'h154.
  - Following cycle `armed`=0.
- Armed persistence/reset:
  - Prefix 8'hD3, then ALU, then JNZ (not taken) → JNZ target uses `pend_page[2:0]`=3; FSM returns to NORMAL.
  - Separately: prefix, then `sync_reset` pulse → `armed`=0 and the next JMP uses `pc_big[9:4]`.
